// File: rtl/hqm_rf_pg_ctl_if.sv
// Datapath access handshake for the power-gated RF.
// req: access wanted this cycle; req_ready: array accessible (taken on req && req_ready).
interface hqm_rf_pg_ctl_if;
    logic req;
    logic req_ready;

    modport master (
        output req,
        input  req_ready
    );

    modport slave (
        input  req,
        output req_ready
    );
endinterface

// File: rtl/hqm_rf_pg_ctl.sv
// Power-gating sequencer for one PG register-file instance: wakes on demand,
// powers down after a programmable idle period, gates datapath access by req_ready.
// Ports: clk, rst (sync, active-high); cfg_autopg_en, cfg_idle_limit, force_wake;
// dp (slave: req in, req_ready out); pwr_enable_b_in out / pwr_enable_b_out ack in;
// pgcb_isol_en, ip_reset_b, pg_state (debug), err_ack_tmo (sticky) out.
// Optional macro HQM_RF_PG_ACK_TMO_EN builds the power-ack timeout counter;
// without it err_ack_tmo is tied to 0.
module hqm_rf_pg_ctl #(
    parameter int unsigned RST_DLY = 4,
    parameter int unsigned IDLE_W  = 8,
    parameter int unsigned TMO_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_autopg_en,
    input  logic [IDLE_W-1:0] cfg_idle_limit,
    input  logic              force_wake,
    hqm_rf_pg_ctl_if.slave    dp,
    output logic              pwr_enable_b_in,
    input  logic              pwr_enable_b_out,
    output logic              pgcb_isol_en,
    output logic              ip_reset_b,
    output logic [2:0]        pg_state,
    output logic              err_ack_tmo
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_PWRUP  = 3'd1,
        S_RSTREL = 3'd2,
        S_ON     = 3'd3,
        S_ISO    = 3'd4,
        S_PWRDN  = 3'd5
    } state_e;

    if (RST_DLY < 1 || RST_DLY > 15 || TMO_W < 2) begin : g_bad_cfg
        $error("hqm_rf_pg_ctl: parameter out of range");
    end

    state_e            state_q, state_d;
    logic [3:0]        dly_q, dly_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              busy;
    logic              hit;

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        idle_d  = idle_q;
        busy    = dp.req | force_wake;
        hit     = cfg_autopg_en && (cfg_idle_limit != '0)
                  && (idle_q == cfg_idle_limit);
        case (state_q)
            S_OFF: begin
                if (busy) state_d = S_PWRUP;
            end
            S_PWRUP: begin
                if (!pwr_enable_b_out) begin
                    state_d = S_RSTREL;
                    dly_d   = 4'(RST_DLY - 1);
                end
            end
            S_RSTREL: begin
                if (dly_q == '0) begin
                    state_d = S_ON;
                    idle_d  = '0;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end
            S_ON: begin
                // Activity beats an idle-limit hit in the same cycle.
                if (busy) begin
                    idle_d = '0;
                end else if (hit) begin
                    state_d = S_ISO;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_ISO: begin
                state_d = S_PWRDN;
            end
            S_PWRDN: begin
                if (pwr_enable_b_out) state_d = S_OFF;
            end
            default: begin
                state_d = S_OFF;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as pg_state (ISO raises isolation before power is removed).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_OFF;
            dly_q           <= '0;
            idle_q          <= '0;
            pwr_enable_b_in <= 1'b1;
            pgcb_isol_en    <= 1'b1;
            ip_reset_b      <= 1'b0;
            dp.req_ready    <= 1'b0;
            pg_state        <= 3'd0;
        end else begin
            state_q         <= state_d;
            dly_q           <= dly_d;
            idle_q          <= idle_d;
            pwr_enable_b_in <= (state_d == S_OFF) || (state_d == S_PWRDN);
            pgcb_isol_en    <= (state_d != S_ON);
            ip_reset_b      <= (state_d == S_RSTREL) || (state_d == S_ON)
                               || (state_d == S_ISO);
            dp.req_ready    <= (state_d == S_ON);
            pg_state        <= state_d;
        end
    end

`ifdef HQM_RF_PG_ACK_TMO_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q;

    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if ((state_q == S_PWRUP || state_q == S_PWRDN)
                     && tmo_q != '1) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Flag only; the sequencer keeps waiting for the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            if (tmo_d == '1) err_q <= 1'b1;
        end
    end

    assign err_ack_tmo = err_q;
`else
    assign err_ack_tmo = 1'b0;
`endif

endmodule

// File: doc/hqm_rf_pg_ctl.md
# hqm_rf_pg_ctl

Power-gating sequencer for a single power-gated register-file instance (64x6 class, with a PG wrapper). It owns the RF's power-enable, isolation and IP-reset pins, and wakes the array on demand. After a programmable idle period it powers the array back down. It sits between the datapath that accesses the RF and the RF PG wrapper, and gates datapath access through a ready signal.

## Interface

Parameters:
- RST_DLY, 4: cycles ip_reset_b is held deasserted, with isolation on, before access is allowed (1..15).
- IDLE_W, 8: width of the idle limit and the idle counter.
- TMO_W, 10: width of the power-ack timeout counter (used only with the macro).

Ports:
- clk  in  1  block clock; also clocks the RF read/write ports.
- rst  in  1  synchronous, active-high reset.
- cfg_autopg_en  in  1  enables idle-driven power-down.
- cfg_idle_limit  in  IDLE_W  idle cycles in ON before power-down; 0 disables auto power-down.
- force_wake  in  1  level; forces power-up and holds the array ON.
- req  in  1  datapath wants RF access this cycle.
- req_ready  out  1  RF is accessible; the access is taken when req && req_ready.
- pwr_enable_b_in  out  1  to the RF wrapper; 0 = power on.
- pwr_enable_b_out  in  1  wrapper power-chain acknowledge; follows pwr_enable_b_in.
- pgcb_isol_en  out  1  RF output isolation.
- ip_reset_b  out  1  RF IP reset; active-low.
- pg_state  out  3  current state encoding (debug).
- err_ack_tmo  out  1  sticky power-ack timeout flag.

## Operation

- All outputs are registered.
- Reset value of every output: pwr_enable_b_in=1, pgcb_isol_en=1, ip_reset_b=0, req_ready=0, pg_state=OFF(0), err_ack_tmo=0.
- State OFF (0): array unpowered.
  - Leave to PWRUP when req or force_wake is 1.
- State PWRUP (1): pwr_enable_b_in=0.
  - Leave to RSTREL when pwr_enable_b_out==0 is sampled.
- State RSTREL (2): ip_reset_b=1, isolation still on.
  - A down-counter runs for RST_DLY cycles, then the state moves to ON.
- State ON (3): pgcb_isol_en=0, req_ready=1.
  - The idle counter clears on entry and on any cycle with req=1 or force_wake=1. Otherwise it increments, saturating.
  - Leave to ISO when cfg_autopg_en=1, cfg_idle_limit!=0 and the counter equals cfg_idle_limit.
- State ISO (4): pgcb_isol_en=1, req_ready=0. Lasts one cycle, then PWRDN.
- State PWRDN (5): ip_reset_b=0, pwr_enable_b_in=1.
  - Leave to OFF when pwr_enable_b_out==1 is sampled.
- Simultaneous req and idle-limit hit in ON: req wins; state stays ON and the counter clears.
- A req or force_wake during ISO or PWRDN does not abort the sequence. The power-down completes, then OFF immediately re-wakes on the next cycle.
- A change to cfg_idle_limit mid-count takes effect on the next compare. A limit below the current count causes no power-down until the counter clears.
- rst asserted in any state returns the block to OFF with the reset output values on the next edge.
- Unused state encodings (6, 7) recover to OFF on the next cycle.

## Timing

- Wake latency: req sampled in OFF at cycle T gives PWRUP at T+1. If the ack is already present at T+1, RSTREL runs from T+2 and ON with req_ready=1 starts at T+2+RST_DLY. The minimum wake latency is therefore 2+RST_DLY cycles.
- Power-down: the idle-limit hit at T gives ISO at T+1 and PWRDN at T+2. With an immediate ack, OFF is reached at T+3.
- req_ready depends only on state, with no combinational path from req. It drops in the same cycle ISO is entered.
- The datapath must hold req until it sees req_ready; the block never drops an accepted request.

## Configuration

- HQM_RF_PG_ACK_TMO_EN defined:
  - A TMO_W counter runs in PWRUP and PWRDN and clears on every state change.
  - When it reaches all-ones, err_ack_tmo is set and stays set until rst. The state keeps waiting for the ack.
- HQM_RF_PG_ACK_TMO_EN undefined:
  - No counter is built, and err_ack_tmo is tied to 0.

## Test plan

- Reset, then req=1 with an ack model of 1-cycle delay: outputs hold their reset values, then PWRUP, RSTREL for 4 cycles, and req_ready=1 exactly 7 cycles after req.
- ON with cfg_autopg_en=1, cfg_idle_limit=5 and no req: ISO after 5 idle cycles, then PWRDN, then OFF. pgcb_isol_en rises before pwr_enable_b_in.
- Idle limit 5, with req=1 on exactly the 5th idle cycle: stay ON and the counter restarts. With force_wake=1: the block never leaves ON.
- req asserted during ISO: the power-down completes to OFF, then the block re-wakes. req_ready stays 0 until the next ON.
- With the macro defined, the ack is never returned in PWRUP: err_ack_tmo=1 after 1023 cycles and stays there. The ack then arrives and the block reaches ON with the flag still 1. rst clears the flag.
- rst pulsed mid-RSTREL: the next cycle is OFF with ip_reset_b=0, pwr_enable_b_in=1 and pgcb_isol_en=1.
